twi_reg_arbiter: RTL and testbench

TWI_REG_ARBITER -- requirements
Module: twi_reg_arbiter

---
 rtl/twi_reg_arbiter.sv | 160 ++++++++++++++++
 tb/tb_twi_reg_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : twi_reg_arbiter
// Brief    : Register bank shared by a TWI slave (SCL-domain write strobe)
//            and a local port; single-cycle commits, fixed TWI-first priority.
//            Optional macro TWI_ARB_IRQ_EN enables per-register dirty bits/irq.
// Revision : 1.0 - initial release
// ============================================================================
module twi_reg_arbiter #(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    twi_addr,
  input  logic [7:0]    twi_data,
  input  logic          twi_strobe,
  output logic [7:0]    twi_rdata,
  input  logic          loc_req,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic          loc_gnt,
  output logic [7:0]    loc_rdata,
  output logic          irq
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TWI_COMMIT = 2'd1,
    LOC_COMMIT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_sync1, r_sync2, r_sync3;
  logic            r_started, r_armed;
  logic            w_twi_pulse;
  logic [7:0]      r_cap_addr, r_cap_data;
  logic            r_twi_pend;
  logic [AW-1:0]   r_loc_addr;
  logic            r_loc_we;
  logic [7:0]      r_loc_wdata;
  logic [7:0]      r_regs [NREGS];
  logic            w_twi_wr, w_loc_wr;

  // Edge detection is armed only by a genuine low sample taken after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_started <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= twi_strobe;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_started <= 1'b1;
      r_armed   <= r_armed | (r_started & ~r_sync1);
    end
  end

  assign w_twi_pulse = r_sync2 & ~r_sync3 & r_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_twi_pend  <= 1'b0;
      r_cap_addr  <= 8'h00;
      r_cap_data  <= 8'h00;
      r_loc_addr  <= '0;
      r_loc_we    <= 1'b0;
      r_loc_wdata <= 8'h00;
      loc_gnt     <= 1'b0;
      loc_rdata   <= 8'h00;
    end else begin
      loc_gnt   <= 1'b0;
      loc_rdata <= 8'h00;
      if (r_state == TWI_COMMIT) begin
        r_twi_pend <= 1'b0;
      end
      // A fresh pulse overrides any clear above; a still-pending write is lost.
      if (w_twi_pulse) begin
        r_cap_addr <= twi_addr;
        r_cap_data <= twi_data;
        r_twi_pend <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (r_twi_pend || w_twi_pulse) begin
            r_state <= TWI_COMMIT;
          end else if (loc_req) begin
            r_state     <= LOC_COMMIT;
            loc_gnt     <= 1'b1;
            loc_rdata   <= r_regs[loc_addr];
            r_loc_addr  <= loc_addr;
            r_loc_we    <= loc_we;
            r_loc_wdata <= loc_wdata;
          end
        end
        TWI_COMMIT: r_state <= IDLE;
        LOC_COMMIT: r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

  assign w_twi_wr = (r_state == TWI_COMMIT) && ((r_cap_addr >> AW) == 8'd0);
  assign w_loc_wr = (r_state == LOC_COMMIT) && r_loc_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 8'h00;
      end
      twi_rdata <= 8'h00;
    end else begin
      if (w_twi_wr) begin
        r_regs[r_cap_addr[AW-1:0]] <= r_cap_data;
      end
      if (w_loc_wr) begin
        r_regs[r_loc_addr] <= r_loc_wdata;
      end
      twi_rdata <= ((twi_addr >> AW) == 8'd0) ? r_regs[twi_addr[AW-1:0]] : 8'hFF;
    end
  end

`ifdef TWI_ARB_IRQ_EN
  logic [NREGS-1:0] r_dirty;
  logic [NREGS-1:0] w_dirty_nxt;
  logic             w_loc_rd;

  assign w_loc_rd = (r_state == LOC_COMMIT) && !r_loc_we;

  // Set is applied last so it wins over a clear of the same bit.
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (w_loc_rd) begin
      w_dirty_nxt[r_loc_addr] = 1'b0;
    end
    if (w_twi_wr) begin
      w_dirty_nxt[r_cap_addr[AW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dirty <= '0;
      irq     <= 1'b0;
    end else begin
      r_dirty <= w_dirty_nxt;
      irq     <= |w_dirty_nxt;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_twi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_twi_reg_arbiter
// Brief    : Randomized bench for twi_reg_arbiter against a slot-based
//            transaction model, plus directed scenarios with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twi_reg_arbiter;
  localparam int NREGS = 16;
  localparam int AW    = 4;
`ifdef TWI_ARB_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    twi_addr = 8'h00;
  logic [7:0]    twi_data = 8'h00;
  logic          twi_strobe = 1'b0;
  logic [7:0]    twi_rdata;
  logic          loc_req = 1'b0;
  logic          loc_we = 1'b0;
  logic [AW-1:0] loc_addr = '0;
  logic [7:0]    loc_wdata = 8'h00;
  logic          loc_gnt;
  logic [7:0]    loc_rdata;
  logic          irq;

  int checks = 0;
  int failures = 0;

  twi_reg_arbiter #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .twi_addr(twi_addr), .twi_data(twi_data), .twi_strobe(twi_strobe),
    .twi_rdata(twi_rdata),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Model: the arbiter owns one commit slot; each commit takes one cycle and
  // is followed by a free cycle. TWI writes (pending or arriving) beat local.
  logic [7:0]       m_regs [NREGS];
  logic [NREGS-1:0] m_dirty;
  int               m_edge;
  logic             m_h1, m_h2, m_h3;
  logic             m_pend, m_pulse, m_pend_was;
  logic [7:0]       m_cap_a, m_cap_d;
  int               m_slot;
  logic             m_lwe;
  logic [AW-1:0]    m_la;
  logic [7:0]       m_ld;
  logic             exp_gnt = 1'b0;
  logic [7:0]       exp_lrd = 8'h00;
  logic [7:0]       exp_trd = 8'h00;
  logic             exp_irq = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      m_dirty = '0;
      m_edge = 0;
      {m_h1, m_h2, m_h3} = 3'b000;
      m_pend = 1'b0;
      m_cap_a = 8'h00;
      m_cap_d = 8'h00;
      m_slot = 0;
      exp_gnt = 1'b0;
      exp_lrd = 8'h00;
      exp_trd = 8'h00;
      exp_irq = 1'b0;
    end else begin
      m_edge++;
      // Strobe samples taken 2 and 3 edges ago, both genuine post-reset samples.
      m_pulse = m_h2 && !m_h3 && (m_edge >= 4);
      m_h3 = m_h2;
      m_h2 = m_h1;
      m_h1 = twi_strobe;
      m_pend_was = m_pend;
      exp_trd = (int'(twi_addr) < NREGS) ? m_regs[twi_addr[AW-1:0]] : 8'hFF;
      if (m_slot == 1) begin
        if (int'(m_cap_a) < NREGS) begin
          m_regs[m_cap_a[AW-1:0]] = m_cap_d;
          m_dirty[m_cap_a[AW-1:0]] = 1'b1;
        end
        m_pend = 1'b0;
      end else if (m_slot == 2) begin
        if (m_lwe) m_regs[m_la] = m_ld;
        else       m_dirty[m_la] = 1'b0;
      end
      if (m_pulse) begin
        m_pend = 1'b1;
        m_cap_a = twi_addr;
        m_cap_d = twi_data;
      end
      exp_gnt = 1'b0;
      exp_lrd = 8'h00;
      if (m_slot != 0) begin
        m_slot = 0;
      end else if (m_pend_was || m_pulse) begin
        m_slot = 1;
      end else if (loc_req) begin
        m_slot = 2;
        exp_gnt = 1'b1;
        exp_lrd = m_regs[loc_addr];
        m_lwe = loc_we;
        m_la = loc_addr;
        m_ld = loc_wdata;
      end
      exp_irq = IRQ_EN ? |m_dirty : 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cmp_loc_gnt", {7'd0, loc_gnt}, {7'd0, exp_gnt});
    check("cmp_loc_rdata", loc_rdata, exp_lrd);
    check("cmp_twi_rdata", twi_rdata, exp_trd);
    check("cmp_irq", {7'd0, irq}, {7'd0, exp_irq});
  end

  task automatic loc_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                            output logic [7:0] rd);
    int n;
    loc_req = 1'b1;
    loc_we = we;
    loc_addr = a;
    loc_wdata = d;
    n = 0;
    rd = 8'h00;
    do begin
      @(negedge clk);
      n++;
    end while (!loc_gnt && n < 20);
    if (!loc_gnt) check("loc_grant_timeout", 8'd0, 8'd1);
    rd = loc_rdata;
    loc_req = 1'b0;
  endtask

  task automatic twi_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    twi_addr = a;
    twi_data = d;
    twi_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    twi_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("reset_twi_rdata", twi_rdata, 8'h00);
    check("reset_loc_gnt", {7'd0, loc_gnt}, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);
    loc_access(1'b0, 4'd3, 8'h00, rd);
    check("read_reg3_after_reset", rd, 8'h00);

    // Long strobe must commit exactly once.
    twi_addr = 8'h05;
    twi_data = 8'hA5;
    twi_strobe = 1'b1;
    repeat (20) @(negedge clk);
    check("twi_rdata_reg5", twi_rdata, 8'hA5);
    twi_strobe = 1'b0;
    repeat (4) @(negedge clk);
    loc_access(1'b0, 4'd5, 8'h00, rd);
    check("read_reg5", rd, 8'hA5);

    // Pulse and local write in the same idle cycle: TWI goes first.
    loc_access(1'b1, 4'd5, 8'h00, rd);
    repeat (2) @(negedge clk);
    twi_addr = 8'h05;
    twi_data = 8'hA5;
    twi_strobe = 1'b1;
    repeat (2) @(negedge clk);
    loc_access(1'b1, 4'd5, 8'h3C, rd);
    check("arb_loc_rdata", rd, 8'hA5);
    repeat (6) @(negedge clk);
    twi_strobe = 1'b0;
    repeat (4) @(negedge clk);
    loc_access(1'b0, 4'd5, 8'h00, rd);
    check("arb_final_reg5", rd, 8'h3C);

    // Out-of-range TWI address.
    twi_write(8'h20, 8'h5A, 5);
    check("oob_twi_rdata", twi_rdata, 8'hFF);
    loc_access(1'b0, 4'd0, 8'h00, rd);
    check("oob_reg0_untouched", rd, 8'h00);

    // Dirty tracking.
    twi_write(8'h02, 8'h11, 3);
    check("irq_after_twi_reg2", {7'd0, irq}, {7'd0, IRQ_EN});
    loc_access(1'b0, 4'd7, 8'h00, rd);
    @(negedge clk);
    check("irq_after_read_reg7", {7'd0, irq}, {7'd0, IRQ_EN});
    loc_access(1'b0, 4'd2, 8'h00, rd);
    check("read_reg2", rd, 8'h11);
    @(negedge clk);
    check("irq_after_read_reg2", {7'd0, irq}, 8'h00);

    // Reset in the middle of a local write commit.
    loc_req = 1'b1;
    loc_we = 1'b1;
    loc_addr = 4'd1;
    loc_wdata = 8'h77;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!loc_gnt && n < 20);
    if (!loc_gnt) check("rst_grant_timeout", 8'd0, 8'd1);
    #2 rst = 1'b1;
    loc_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    loc_access(1'b0, 4'd1, 8'h00, rd);
    check("reg1_after_midcommit_reset", rd, 8'h00);

    // Randomized concurrent traffic.
    fork
      begin : twi_proc
        for (int k = 0; k < 60; k++) begin
          twi_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255))
                                                 : 8'($urandom_range(0, 15));
          twi_data = 8'($urandom);
          twi_strobe = 1'b1;
          repeat ($urandom_range(1, 12)) @(negedge clk);
          twi_strobe = 1'b0;
          repeat ($urandom_range(1, 15)) @(negedge clk);
        end
      end
      begin : loc_proc
        logic [7:0] rd2;
        for (int k = 0; k < 150; k++) begin
          if ($urandom_range(0, 9) == 0) begin
            // Short request that may be withdrawn before any grant.
            loc_req = 1'b1;
            loc_we = 1'b1;
            loc_addr = AW'($urandom_range(0, NREGS - 1));
            loc_wdata = 8'($urandom);
            @(negedge clk);
            loc_req = 1'b0;
          end else begin
            loc_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)),
                       8'($urandom), rd2);
          end
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
      end
    join
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
